// File: rtl/ddr_gearbox_pkg.sv
// Shared constants, stream-state encoding and sizing helper for the DDR lane gearbox.
package ddr_gearbox_pkg;
  localparam int              DEF_WIDTH     = 14;
  localparam logic [13:0]     DEF_IDLE_WORD = 14'h2AAA;

  typedef enum logic {ST_IDLE, ST_PRIMED} stream_st_e;

  function automatic int min_buf_words(input int in_lanes, input int out_lanes);
    return in_lanes + out_lanes;
  endfunction
endpackage

// File: rtl/gearbox_word_buf.sv
// Ordered word store: head at slot 0, pops shift the store down, pushes append after the survivors.
module gearbox_word_buf #(
  parameter int WIDTH     = 14,
  parameter int IN_LANES  = 5,
  parameter int OUT_LANES = 2,
  parameter int BUF_WORDS = 16,
  localparam int FW       = $clog2(BUF_WORDS + 1)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               push,
  input  logic                               pop,
  input  logic [IN_LANES-1:0][WIDTH-1:0]     push_words,
  output logic [OUT_LANES-1:0][WIDTH-1:0]    head_words,
  output logic [FW-1:0]                      fill
);
  logic [BUF_WORDS-1:0][WIDTH-1:0]           mem_q, mem_d;
  logic [BUF_WORDS+OUT_LANES-1:0][WIDTH-1:0] ext;
  logic [FW-1:0]                             fill_d, base;

  // Zero-extend above the top so the popped shift never indexes out of range.
  assign ext        = {{(OUT_LANES*WIDTH){1'b0}}, mem_q};
  assign head_words = mem_q[OUT_LANES-1:0];

  always_comb begin
    base   = pop ? fill - FW'(OUT_LANES) : fill;
    fill_d = fill + (push ? FW'(IN_LANES) : FW'(0)) - (pop ? FW'(OUT_LANES) : FW'(0));
    mem_d  = mem_q;
    for (int i = 0; i < BUF_WORDS; i++) begin
      if (pop) mem_d[i] = ext[i+OUT_LANES];
      if (push) begin
        for (int j = 0; j < IN_LANES; j++)
          if (FW'(i) == base + FW'(j)) mem_d[i] = push_words[j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
      fill  <= '0;
    end else begin
      mem_q <= mem_d;
      fill  <= fill_d;
    end
  end
endmodule

// File: rtl/ddr_lane_gearbox.sv
// IN_LANES-to-OUT_LANES word gearbox with valid/ready, stream mode idle fill and underrun counting.
module ddr_lane_gearbox
  import ddr_gearbox_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter int               IN_LANES    = 5,
  parameter int               OUT_LANES   = 2,
  parameter int               BUF_WORDS   = 16,
  parameter int               PRIME_WORDS = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD   = WIDTH'(DEF_IDLE_WORD),
  localparam int              FW          = $clog2(BUF_WORDS + 1)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [IN_LANES-1:0][WIDTH-1:0]  data_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_LANES-1:0][WIDTH-1:0] data_out,
  input  logic                            stream_en,
  input  logic                            cnt_clr,
  output logic [FW-1:0]                   fill,
  output logic [15:0]                     underrun_cnt
);
  if (BUF_WORDS < min_buf_words(IN_LANES, OUT_LANES)) begin : g_buf_chk
    $error("ddr_lane_gearbox: BUF_WORDS too small for IN_LANES+OUT_LANES");
  end
  if (PRIME_WORDS < OUT_LANES || PRIME_WORDS > BUF_WORDS) begin : g_prime_chk
    $error("ddr_lane_gearbox: PRIME_WORDS out of range");
  end

  logic                            stream_q;
  stream_st_e                      st_q, st_d;
  logic [15:0]                     cnt_q, cnt_d;
  logic                            push, pop, have_beat, show_head, underrun;
  logic [OUT_LANES-1:0][WIDTH-1:0] head;

  assign have_beat = fill >= FW'(OUT_LANES);
  assign in_ready  = fill <= FW'(BUF_WORDS - IN_LANES);
  assign push      = in_valid & in_ready;
  // Stream mode only releases head words once primed; idle cycles never pop.
  assign show_head = !stream_q | ((st_q == ST_PRIMED) & have_beat);
  assign pop       = out_ready & have_beat & show_head;
  assign underrun  = stream_q & (st_q == ST_PRIMED) & !have_beat;
  assign out_valid = stream_q | have_beat;

  always_comb begin
    for (int l = 0; l < OUT_LANES; l++)
      data_out[l] = show_head ? head[l] : IDLE_WORD;
  end

  gearbox_word_buf #(
    .WIDTH    (WIDTH),
    .IN_LANES (IN_LANES),
    .OUT_LANES(OUT_LANES),
    .BUF_WORDS(BUF_WORDS)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .push_words(data_in),
    .head_words(head),
    .fill      (fill)
  );

  always_comb begin
    st_d = st_q;
    if (!stream_q) st_d = ST_IDLE;
    else begin
      case (st_q)
        ST_IDLE:   if (fill >= FW'(PRIME_WORDS)) st_d = ST_PRIMED;
        ST_PRIMED: if (!have_beat) st_d = ST_IDLE;
        default:   st_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) cnt_d = '0;
    else if (underrun && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  assign underrun_cnt = cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stream_q <= 1'b0;
      st_q     <= ST_IDLE;
      cnt_q    <= '0;
    end else begin
      stream_q <= stream_en;
      st_q     <= st_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule
